// File: rtl/ledkey_responder.sv
// ledkey_responder: TM1638-compatible device end of the LED&KEY serial link.
// Decodes command/address/data bytes into a 16-byte display RAM and
// display-control state, and optionally shifts a key snapshot back out.
//
// Parameters:
//   SYNC_STAGES   synchroniser depth for the link inputs (2 or 3)
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   i_lk_clk/stb/dio       serial clock, strobe (active low), data in
//   o_lk_dio, o_lk_dio_oe  data out and pad output enable
//   i_keys                 32-bit key snapshot, byte k sent k-th, LSB first
//   i_ram_addr/o_ram_data  combinational display-RAM read port
//   o_display_on           display enable
//   o_brightness           pulse-width setting
//   o_frame_done           one-cycle pulse at close of a frame with >=1 byte
// Build option:
//   TM1638_RESP_READ_EN    enables the key read-back path
module ledkey_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_lk_clk,
    input  logic        i_lk_stb,
    input  logic        i_lk_dio,
    output logic        o_lk_dio,
    output logic        o_lk_dio_oe,
    input  logic [31:0] i_keys,
    input  logic [3:0]  i_ram_addr,
    output logic [7:0]  o_ram_data,
    output logic        o_display_on,
    output logic [2:0]  o_brightness,
    output logic        o_frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_READ,
        S_SKIP
    } state_t;

    state_t r_state;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_dio_sync;
    logic                   r_clk_d;
    logic                   r_stb_d;

    logic w_clk;
    logic w_stb;
    logic w_dio;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_stb_rise;
    logic w_stb_fall;
    logic w_capture;

    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_byte_vld;
    logic       r_byte_seen;
    logic [7:0] r_ram [16];
    logic [3:0] r_ptr;
    logic       r_read_mode;
    logic       r_fixed;
    logic       r_disp_on;
    logic [2:0] r_bright;
    logic       r_frame_done;

`ifdef TM1638_RESP_READ_EN
    logic [31:0] r_key;
    logic [5:0]  r_rd_cnt;
    logic        r_dio;
    logic        r_dio_oe;
`endif

    // Clock and strobe idle high, so their synchronisers reset high to
    // avoid a false edge right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_stb_sync <= '1;
            r_dio_sync <= '0;
            r_clk_d    <= 1'b1;
            r_stb_d    <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_lk_clk};
            r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], i_lk_stb};
            r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], i_lk_dio};
            r_clk_d    <= w_clk;
            r_stb_d    <= w_stb;
        end
    end

    assign w_clk      = r_clk_sync[SYNC_STAGES-1];
    assign w_stb      = r_stb_sync[SYNC_STAGES-1];
    assign w_dio      = r_dio_sync[SYNC_STAGES-1];
    assign w_clk_rise = w_clk & ~r_clk_d;
    assign w_clk_fall = ~w_clk & r_clk_d;
    assign w_stb_rise = w_stb & ~r_stb_d;
    assign w_stb_fall = ~w_stb & r_stb_d;

    // Master-driven bits are only meaningful outside IDLE and READ.
    assign w_capture = w_clk_rise &&
                       (r_state == S_CMD || r_state == S_WDATA ||
                        r_state == S_SKIP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_byte_vld   <= 1'b0;
            r_byte_seen  <= 1'b0;
            r_ptr        <= 4'd0;
            r_read_mode  <= 1'b0;
            r_fixed      <= 1'b0;
            r_disp_on    <= 1'b0;
            r_bright     <= 3'd0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_ram[i] <= 8'h00;
            end
`ifdef TM1638_RESP_READ_EN
            r_key        <= 32'h0;
            r_rd_cnt     <= 6'd0;
            r_dio        <= 1'b0;
            r_dio_oe     <= 1'b0;
`endif
        end else begin
            r_byte_vld   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_stb_rise) begin
                // Strobe rise beats any coincident clock edge and drops
                // a partial byte or a pending byte.
                r_state      <= S_IDLE;
                r_bitcnt     <= 3'd0;
                r_frame_done <= r_byte_seen;
                r_byte_seen  <= 1'b0;
`ifdef TM1638_RESP_READ_EN
                r_dio        <= 1'b0;
                r_dio_oe     <= 1'b0;
`endif
            end else if (w_stb_fall) begin
                r_state     <= S_CMD;
                r_bitcnt    <= 3'd0;
                r_byte_seen <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_shift  <= {w_dio, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_byte_vld  <= 1'b1;
                        r_byte_seen <= 1'b1;
                    end
                end
                if (r_byte_vld) begin
                    unique case (r_state)
                        S_CMD: begin
                            unique case (r_shift[7:6])
                                2'b01: begin
                                    r_read_mode <= r_shift[1];
                                    r_fixed     <= r_shift[2];
                                    r_state     <= S_SKIP;
`ifdef TM1638_RESP_READ_EN
                                    if (r_shift[1]) begin
                                        r_key    <= i_keys;
                                        r_rd_cnt <= 6'd0;
                                        r_state  <= S_READ;
                                    end
`endif
                                end
                                2'b10: begin
                                    r_disp_on <= r_shift[3];
                                    r_bright  <= r_shift[2:0];
                                    r_state   <= S_SKIP;
                                end
                                2'b11: begin
                                    r_ptr   <= r_shift[3:0];
                                    r_state <= S_WDATA;
                                end
                                default: r_state <= S_SKIP;
                            endcase
                        end
                        S_WDATA: begin
                            r_ram[r_ptr] <= r_shift;
                            if (!r_fixed) begin
                                r_ptr <= r_ptr + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
`ifdef TM1638_RESP_READ_EN
                // 33rd falling edge releases the pad after bit 31.
                if (r_state == S_READ && w_clk_fall) begin
                    if (r_rd_cnt == 6'd32) begin
                        r_dio    <= 1'b0;
                        r_dio_oe <= 1'b0;
                        r_state  <= S_SKIP;
                    end else begin
                        r_dio    <= r_key[0];
                        r_dio_oe <= 1'b1;
                        r_key    <= {1'b0, r_key[31:1]};
                        r_rd_cnt <= r_rd_cnt + 6'd1;
                    end
                end
`endif
            end
        end
    end

    assign o_ram_data   = r_ram[i_ram_addr];
    assign o_display_on = r_disp_on;
    assign o_brightness = r_bright;
    assign o_frame_done = r_frame_done;

`ifdef TM1638_RESP_READ_EN
    logic w_unused;
    assign w_unused    = r_read_mode;
    assign o_lk_dio    = r_dio;
    assign o_lk_dio_oe = r_dio_oe;
`else
    // Mode bit and key inputs have no consumer without the read path.
    logic w_unused;
    assign w_unused    = ^{i_keys, r_read_mode, w_clk_fall};
    assign o_lk_dio    = 1'b0;
    assign o_lk_dio_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ledkey_responder.sv
// tb_ledkey_responder: directed bench for ledkey_responder.
// Drives the serial link as master and checks RAM, control and read-back.
module tb_ledkey_responder;

    localparam int PH = 6;

    logic        clk;
    logic        rst_n;
    logic        lk_clk;
    logic        lk_stb;
    logic        lk_dio;
    logic        dio_out;
    logic        dio_oe;
    logic [31:0] keys;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        disp_on;
    logic [2:0]  bright;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;

    ledkey_responder #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lk_clk     (lk_clk),
        .i_lk_stb     (lk_stb),
        .i_lk_dio     (lk_dio),
        .o_lk_dio     (dio_out),
        .o_lk_dio_oe  (dio_oe),
        .i_keys       (keys),
        .i_ram_addr   (ram_addr),
        .o_ram_data   (ram_data),
        .o_display_on (disp_on),
        .o_brightness (bright),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic       exp_on;
        logic [2:0] exp_br;
    } dvec_t;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ram(input logic [3:0] a, input logic [7:0] exp);
        ram_addr = a;
        #1;
        check($sformatf("ram[%0d]", a), {24'h0, ram_data}, {24'h0, exp});
    endtask

    task automatic frame_start();
        lk_stb = 1'b0;
        wait_cyc(PH);
    endtask

    task automatic frame_end();
        lk_stb = 1'b1;
        wait_cyc(2 * PH);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            lk_clk = 1'b0;
            lk_dio = b[i];
            wait_cyc(PH);
            lk_clk = 1'b1;
            wait_cyc(PH);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cmd_frame(input logic [7:0] b);
        frame_start();
        send_byte(b);
        frame_end();
    endtask

    initial begin
        dvec_t       dv[4];
        logic [7:0]  rd_exp[4];
        logic [31:0] got;
        int          oe_cnt;
        int          fd0;

        dv[0] = '{8'h8D, 1'b1, 3'd5};
        dv[1] = '{8'h87, 1'b0, 3'd7};
        dv[2] = '{8'h88, 1'b1, 3'd0};
        dv[3] = '{8'h82, 1'b0, 3'd2};
        rd_exp[0] = 8'h01;
        rd_exp[1] = 8'h20;
        rd_exp[2] = 8'h40;
        rd_exp[3] = 8'h80;

        rst_n    = 1'b0;
        lk_clk   = 1'b1;
        lk_stb   = 1'b1;
        lk_dio   = 1'b0;
        keys     = 32'h0;
        ram_addr = 4'd0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);

        check("rst_disp_on", {31'h0, disp_on}, 32'h0);
        check("rst_bright", {29'h0, bright}, 32'h0);
        check("rst_oe", {31'h0, dio_oe}, 32'h0);
        check("rst_dio", {31'h0, dio_out}, 32'h0);
        check("rst_fd", {31'h0, frame_done}, 32'h0);
        check_ram(4'd0, 8'h00);
        check_ram(4'd15, 8'h00);

        // reset in the middle of a write burst
        cmd_frame(8'h8F);
        check("pre_rst_on", {31'h0, disp_on}, 32'h1);
        cmd_frame(8'h40);
        frame_start();
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_byte(8'hEE);
        check_ram(4'd0, 8'hFF);
        send_bits(8'h33, 3);
        rst_n  = 1'b0;
        wait_cyc(2);
        lk_stb = 1'b1;
        lk_clk = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < 16; i++) check_ram(i[3:0], 8'h00);
        check("mrst_on", {31'h0, disp_on}, 32'h0);
        check("mrst_oe", {31'h0, dio_oe}, 32'h0);

        // auto-increment burst over the whole RAM
        fd0 = fd_cnt;
        cmd_frame(8'h40);
        check("fd_cmd40", fd_cnt - fd0, 1);
        fd0 = fd_cnt;
        frame_start();
        send_byte(8'hC0);
        for (int i = 1; i <= 16; i++) send_byte(i[7:0]);
        frame_end();
        check("fd_burst", fd_cnt - fd0, 1);
        for (int i = 0; i < 16; i++) check_ram(i[3:0], 8'(i + 1));

        // empty frame: no complete byte, no pulse
        fd0 = fd_cnt;
        frame_start();
        frame_end();
        check("fd_empty", fd_cnt - fd0, 0);

        // fixed address mode
        cmd_frame(8'h44);
        frame_start();
        send_byte(8'hCE);
        send_byte(8'hAA);
        send_byte(8'hBB);
        frame_end();
        check_ram(4'd14, 8'hBB);
        check_ram(4'd15, 8'h10);

        // auto-increment wrap 15 -> 0
        cmd_frame(8'h40);
        frame_start();
        send_byte(8'hCF);
        send_byte(8'h11);
        send_byte(8'h22);
        frame_end();
        check_ram(4'd15, 8'h11);
        check_ram(4'd0, 8'h22);
        check_ram(4'd1, 8'h02);

        // display control table
        for (int i = 0; i < 4; i++) begin
            cmd_frame(dv[i].cmd);
            check($sformatf("disp_on_%0d", i), {31'h0, disp_on},
                  {31'h0, dv[i].exp_on});
            check($sformatf("bright_%0d", i), {29'h0, bright},
                  {29'h0, dv[i].exp_br});
        end

        // key read-back
        keys = 32'h8040_2001;
        frame_start();
        send_byte(8'h42);
        got    = 32'h0;
        oe_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            lk_clk = 1'b0;
            wait_cyc(PH);
            if (dio_oe === 1'b1) oe_cnt++;
            lk_clk = 1'b1;
            got[i] = dio_out;
            wait_cyc(PH);
        end
        lk_clk = 1'b0;
        wait_cyc(PH);
        check("rd_oe_end", {31'h0, dio_oe}, 32'h0);
        lk_clk = 1'b1;
        wait_cyc(PH);
        frame_end();
        check("rd_oe_idle", {31'h0, dio_oe}, 32'h0);
`ifdef TM1638_RESP_READ_EN
        check("rd_oe_cnt", oe_cnt, 32);
        for (int k = 0; k < 4; k++)
            check($sformatf("rd_byte%0d", k), {24'h0, got[8*k +: 8]},
                  {24'h0, rd_exp[k]});
`else
        check("rd_oe_cnt", oe_cnt, 0);
        check("rd_bits", got, 32'h0);
`endif

        // strobe rise mid-byte drops the partial byte
        cmd_frame(8'h40);
        fd0 = fd_cnt;
        frame_start();
        send_byte(8'hC3);
        send_byte(8'h5A);
        send_bits(8'h77, 5);
        frame_end();
        check("fd_partial", fd_cnt - fd0, 1);
        check_ram(4'd3, 8'h5A);
        check_ram(4'd4, 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
